// File: rtl/rom_arb_pkg.sv
// Shared types for the character/graphics ROM arbiter: owner tags, grant state
// encodings and default ROM geometry.
package rom_arb_pkg;

  localparam int unsigned ROM_ADDR_W = 14;
  localparam int unsigned ROM_DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2
  } owner_e;

  typedef logic [1:0] gnt_state_t;
  localparam gnt_state_t GST_IDLE = 2'd0;
  localparam gnt_state_t GST_CPU  = 2'd1;
  localparam gnt_state_t GST_VID  = 2'd2;

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side bundle of the ROM arbiter: CPU and video read ports plus the
// grant state for debug. master = requesters, slave = arbiter.
interface rom_arbiter_if #(
  parameter int unsigned ADDR_W = rom_arb_pkg::ROM_ADDR_W,
  parameter int unsigned DATA_W = rom_arb_pkg::ROM_DATA_W
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_rvalid;

  rom_arb_pkg::gnt_state_t gnt_state;

  modport master (
    output cpu_req, cpu_addr, vid_req, vid_addr,
    input  cpu_ack, cpu_rdata, cpu_rvalid, vid_ack, vid_rdata, vid_rvalid, gnt_state
  );

  modport slave (
    input  cpu_req, cpu_addr, vid_req, vid_addr,
    output cpu_ack, cpu_rdata, cpu_rvalid, vid_ack, vid_rdata, vid_rvalid, gnt_state
  );

endinterface

// File: rtl/rom_arb_tag_pipe.sv
// Two-deep owner tag shift register that tracks each access through the ROM's
// registered read; stage 1 marks the cycle in which rom_Dout is valid.
module rom_arb_tag_pipe
  import rom_arb_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  owner_e tag_in,
  output owner_e tag_out,
  output logic   busy
);

  owner_e s0_q, s1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q <= OWN_NONE;
      s1_q <= OWN_NONE;
    end else begin
      s0_q <= tag_in;
      s1_q <= s0_q;
    end
  end

  assign tag_out = s1_q;
  assign busy    = (s0_q != OWN_NONE) || (s1_q != OWN_NONE);

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates one registered-read ROM between CPU and video, video first.
// Define ROM_ARB_FAIR_EN to bound CPU waiting to MAX_STREAK video grants.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ROM_ADDR_W,
  parameter int unsigned DATA_W     = ROM_DATA_W,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  rom_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] rom_A,
  output logic              rom_CS_b,
  output logic              rom_OE_b,
  input  logic [DATA_W-1:0] rom_Dout,
  output logic              busy
);

  // The streak counter is 3 bits wide.
  if (MAX_STREAK == 0 || MAX_STREAK > 7) begin : g_bad_streak
    $error("MAX_STREAK must lie in 1..7");
  end

  owner_e            grant;
  owner_e            tag_s1;
  logic              cpu_force;
  gnt_state_t        state_q;
  logic [DATA_W-1:0] cpu_rdata_q, vid_rdata_q;
  logic              cpu_rvalid_q, vid_rvalid_q;

  always_comb begin
    grant = OWN_NONE;
    if (!reset) begin
      if (cpu_force)        grant = OWN_CPU;
      else if (bus.vid_req) grant = OWN_VID;
      else if (bus.cpu_req) grant = OWN_CPU;
    end
  end

  assign bus.cpu_ack = (grant == OWN_CPU);
  assign bus.vid_ack = (grant == OWN_VID);

`ifdef ROM_ARB_FAIR_EN
  localparam logic [2:0] StreakMax = 3'(MAX_STREAK);
  logic [2:0] streak_q;

  // Counts video wins only while the CPU is actually waiting.
  always_ff @(posedge clk) begin
    if (reset || !bus.cpu_req || grant == OWN_CPU) begin
      streak_q <= 3'd0;
    end else if (grant == OWN_VID && streak_q != StreakMax) begin
      streak_q <= streak_q + 3'd1;
    end
  end

  assign cpu_force = bus.cpu_req && (streak_q == StreakMax);
`else
  assign cpu_force = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_A    <= '0;
      rom_CS_b <= 1'b1;
      rom_OE_b <= 1'b1;
      state_q  <= GST_IDLE;
    end else begin
      unique case (grant)
        OWN_CPU: begin
          rom_A    <= bus.cpu_addr;
          rom_CS_b <= 1'b0;
          rom_OE_b <= 1'b0;
          state_q  <= GST_CPU;
        end
        OWN_VID: begin
          rom_A    <= bus.vid_addr;
          rom_CS_b <= 1'b0;
          rom_OE_b <= 1'b0;
          state_q  <= GST_VID;
        end
        default: begin
          rom_CS_b <= 1'b1;
          rom_OE_b <= 1'b1;
          state_q  <= GST_IDLE;
        end
      endcase
    end
  end

  rom_arb_tag_pipe u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (grant),
    .tag_out (tag_s1),
    .busy    (busy)
  );

  // rom_Dout is sampled only for a tagged access, so an undriven bus never leaks.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata_q  <= '0;
      vid_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      vid_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q <= (tag_s1 == OWN_CPU);
      vid_rvalid_q <= (tag_s1 == OWN_VID);
      if (tag_s1 == OWN_CPU) cpu_rdata_q <= rom_Dout;
      if (tag_s1 == OWN_VID) vid_rdata_q <= rom_Dout;
    end
  end

  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.vid_rdata  = vid_rdata_q;
  assign bus.vid_rvalid = vid_rvalid_q;
  assign bus.gnt_state  = state_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: per-cycle ack vector table, scoreboarded read data
// against a registered-read ROM model, plus reset, idle and fairness sequences.
module tb_rom_arbiter;
  import rom_arb_pkg::*;

`ifdef ROM_ARB_FAIR_EN
  localparam bit Fair = 1'b1;
`else
  localparam bit Fair = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] rom_A;
  logic        rom_CS_b, rom_OE_b, busy;
  wire  [7:0]  rom_Dout;

  rom_arbiter_if #(.ADDR_W(14), .DATA_W(8)) bus ();

  rom_arbiter #(.ADDR_W(14), .DATA_W(8), .MAX_STREAK(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .rom_A    (rom_A),
    .rom_CS_b (rom_CS_b),
    .rom_OE_b (rom_OE_b),
    .rom_Dout (rom_Dout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [13:0] a);
    if (a == 14'h0123) return 8'hA5;
    return a[7:0] ^ {a[13:8], 2'b10} ^ 8'h3C;
  endfunction

  // ROM model: registered read, drives Z when not selected.
  logic [7:0] mem [16384];
  logic [7:0] rom_dq;
  logic       rom_sel_q = 1'b0;
  initial for (int a = 0; a < 16384; a++) mem[a] = rom_val(14'(a));
  always @(posedge clk) begin
    rom_sel_q <= !rom_CS_b && !rom_OE_b;
    if (!rom_CS_b && !rom_OE_b) rom_dq <= mem[rom_A];
  end
  assign rom_Dout = rom_sel_q ? rom_dq : 8'bz;

  int n_tot = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Scoreboard: expected data and the negedge cycle at which rvalid must show.
  typedef struct {
    logic [7:0] data;
    int         due;
  } sb_t;
  sb_t  cpu_q[$], vid_q[$];
  logic cpu_exp, vid_exp;

  always @(negedge clk) begin
    if (reset) begin
      cpu_q.delete();
      vid_q.delete();
    end else begin
      cpu_exp = (cpu_q.size() > 0) && (cpu_q[0].due == cyc);
      if (bus.cpu_rvalid || cpu_exp) begin
        chk("cpu_rvalid", bus.cpu_rvalid, cpu_exp);
        if (bus.cpu_rvalid && cpu_exp) chk("cpu_rdata", bus.cpu_rdata, cpu_q[0].data);
        if (cpu_exp) void'(cpu_q.pop_front());
      end
      vid_exp = (vid_q.size() > 0) && (vid_q[0].due == cyc);
      if (bus.vid_rvalid || vid_exp) begin
        chk("vid_rvalid", bus.vid_rvalid, vid_exp);
        if (bus.vid_rvalid && vid_exp) chk("vid_rdata", bus.vid_rdata, vid_q[0].data);
        if (vid_exp) void'(vid_q.pop_front());
      end
      if (bus.cpu_req && bus.cpu_ack) cpu_q.push_back('{rom_val(bus.cpu_addr), cyc + 3});
      if (bus.vid_req && bus.vid_ack) vid_q.push_back('{rom_val(bus.vid_addr), cyc + 3});
    end
  end

  // Requesters must hold req and addr stable until acked.
  logic        cpu_pend = 1'b0, vid_pend = 1'b0;
  logic [13:0] cpu_pa, vid_pa;
  always @(posedge clk) begin
    if (!reset && cpu_pend)
      assert (bus.cpu_req && bus.cpu_addr == cpu_pa) else $error("cpu request dropped early");
    if (!reset && vid_pend)
      assert (bus.vid_req && bus.vid_addr == vid_pa) else $error("vid request dropped early");
    cpu_pend <= !reset && bus.cpu_req && !bus.cpu_ack;
    vid_pend <= !reset && bus.vid_req && !bus.vid_ack;
    cpu_pa   <= bus.cpu_addr;
    vid_pa   <= bus.vid_addr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        cpu_req;
    logic [13:0] cpu_addr;
    logic        vid_req;
    logic [13:0] vid_addr;
    logic        exp_cpu_ack;
    logic        exp_vid_ack;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic cr, input logic [13:0] ca, input logic vr,
                     input logic [13:0] va, input logic ec, input logic ev);
    vecs.push_back('{cr, ca, vr, va, ec, ev});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cs"}, rom_CS_b, 1'b1);
    chk({tag, "_oe"}, rom_OE_b, 1'b1);
    chk({tag, "_rom_a"}, rom_A, 14'h0);
    chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 8'h00);
    chk({tag, "_vid_rdata"}, bus.vid_rdata, 8'h00);
    chk({tag, "_rvalids"}, {bus.cpu_rvalid, bus.vid_rvalid}, 2'b00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_state"}, bus.gnt_state, GST_IDLE);
  endtask

  int          cpu_at, vid_acks, vid_before;
  logic [13:0] va;

  initial begin
    reset = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 14'h0001;
    bus.vid_req = 1'b1; bus.vid_addr = 14'h0002;
    repeat (3) step();
    @(negedge clk);
    chk("reset_acks", {bus.cpu_ack, bus.vid_ack}, 2'b00);
    chk_reset_vals("reset");
    bus.cpu_req = 1'b0;
    bus.vid_req = 1'b0;
    step();
    reset = 1'b0;

    // Single CPU read, video burst, simultaneous pair, short video-over-CPU wait.
    add(1, 14'h0123, 0, 14'h0000, 1, 0);
    repeat (3) add(0, 14'h0000, 0, 14'h0000, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 14'h0000, 1, 14'(i), 0, 1);
    add(1, 14'h2000, 1, 14'h0010, 0, 1);
    add(1, 14'h2000, 0, 14'h0000, 1, 0);
    repeat (3) add(0, 14'h0000, 0, 14'h0000, 0, 0);
    add(1, 14'h1234, 1, 14'h0100, 0, 1);
    add(1, 14'h1234, 1, 14'h0101, 0, 1);
    add(1, 14'h1234, 0, 14'h0000, 1, 0);
    repeat (3) add(0, 14'h0000, 0, 14'h0000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.cpu_req = vecs[i].cpu_req; bus.cpu_addr = vecs[i].cpu_addr;
      bus.vid_req = vecs[i].vid_req; bus.vid_addr = vecs[i].vid_addr;
      @(negedge clk);
      chk($sformatf("vec%0d_acks", i), {bus.cpu_ack, bus.vid_ack},
          {vecs[i].exp_cpu_ack, vecs[i].exp_vid_ack});
      if (i == 1) chk("busy_after_accept", busy, 1'b1);
      step();
    end

    // Idle with ROM undriven: read data holds, nothing valid, not busy.
    bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_cpu_rdata_hold", bus.cpu_rdata, rom_val(14'h1234));
      chk("idle_vid_rdata_hold", bus.vid_rdata, rom_val(14'h0101));
      chk("idle_busy_cs", {busy, rom_CS_b, bus.cpu_rvalid, bus.vid_rvalid}, 4'b0100);
      step();
    end

    // Saturated video load with a waiting CPU.
    cpu_at = -1; vid_acks = 0; vid_before = 0; va = 14'h0200;
    for (int i = 0; i < 10; i++) begin
      bus.cpu_req = (cpu_at < 0); bus.cpu_addr = 14'h3ABC;
      bus.vid_req = 1'b1;         bus.vid_addr = va;
      @(negedge clk);
      if (bus.cpu_req && bus.cpu_ack) begin
        cpu_at = i;
        vid_before = vid_acks;
      end
      if (bus.vid_ack) begin
        vid_acks++;
        va++;
      end
      step();
    end
    chk("fair_cpu_ack_cycle", cpu_at, Fair ? 4 : -1);
    chk("fair_vid_before_cpu", vid_before, Fair ? 4 : 0);
    chk("fair_vid_acks", vid_acks, Fair ? 9 : 10);
    bus.vid_req = 1'b0;
    bus.cpu_req = (cpu_at < 0);
    @(negedge clk);
    chk("cpu_after_video_drop", bus.cpu_ack, (cpu_at < 0));
    step();
    bus.cpu_req = 1'b0;
    repeat (4) step();

    // Reset one cycle after an accept flushes the in-flight read.
    bus.cpu_req = 1'b1; bus.cpu_addr = 14'h0ABC;
    @(negedge clk);
    chk("pre_reset_ack", bus.cpu_ack, 1'b1);
    step();
    bus.cpu_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("busy_inflight", busy, 1'b1);
    step();
    @(negedge clk);
    chk_reset_vals("midreset");
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_rvalid_after_reset", {bus.cpu_rvalid, bus.vid_rvalid}, 2'b00);
      step();
    end
    bus.cpu_req = 1'b1; bus.cpu_addr = 14'h0123;
    @(negedge clk);
    chk("post_reset_ack", bus.cpu_ack, 1'b1);
    step();
    bus.cpu_req = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("post_reset_rdata", bus.cpu_rdata, 8'hA5);
    chk("post_reset_idle", {busy, rom_CS_b}, 2'b01);
    chk("sb_drained", cpu_q.size() + vid_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares one 16K×8 character/graphics ROM (control_23128-style: registered read, active-low CS_b/OE_b) between the 6502 CPU read path and the video tile fetcher. Issues at most one ROM access per clock, tags each access with its owner through the ROM's read pipeline, and returns data to the correct requester in order. Video has priority, with an optional fairness limit so the CPU is not starved.

## Interface
- ADDR_W, 14, ROM address width
- DATA_W, 8, ROM data width
- MAX_STREAK, 4, consecutive video grants allowed while CPU waits (fairness build only)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU read request; hold with cpu_addr stable until cpu_ack
- cpu_addr  in  ADDR_W  CPU read address
- cpu_ack  out  1  combinational; request accepted on this edge
- cpu_rdata  out  DATA_W  registered read data
- cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
- vid_req, vid_addr, vid_ack, vid_rdata, vid_rvalid: same as cpu_* for the video fetcher
- rom_A  out  ADDR_W  registered ROM address
- rom_CS_b  out  1  registered ROM chip select, active-low
- rom_OE_b  out  1  registered ROM output enable, active-low
- rom_Dout  in  DATA_W  ROM data; Z or don't-care when not selected
- busy  out  1  any access in flight (tag pipe non-empty)

## Operation
- Grant each cycle (combinational, not during reset): vid_req → video; else cpu_req → CPU; else none.
- Fairness build: if cpu_req && streak == MAX_STREAK, CPU wins over video.
- Accept = req && ack. On the accepting edge: rom_A ← addr, rom_CS_b ← 0, rom_OE_b ← 0, owner tag enters stage 0. No grant: rom_CS_b ← 1, rom_OE_b ← 1, rom_A holds, tag NONE.
- Grant state register: IDLE (last cycle no grant), CPU, VID. Next state follows the winner; used for streak and debug only.
- Streak counter, 3 bits, saturating at MAX_STREAK: +1 on a video grant while cpu_req is high; cleared on a CPU grant or when cpu_req is low.
- Tag pipeline, 2 stages: stage 0 ↔ ROM sampling address, stage 1 ↔ rom_Dout valid. When stage 1 = CPU: cpu_rdata ← rom_Dout, cpu_rvalid ← 1 for one cycle; likewise for VID. NONE: rdata holds, rvalid 0.
- rom_Dout is never captured while stage 1 = NONE, so Z from the ROM never propagates.
- Back-to-back accesses are fully pipelined: throughput 1 per cycle; per-port responses in issue order.

## Timing
- Request accepted at edge k → ROM latches at k+1 → rvalid high in the cycle after edge k+2. Latency 2 cycles, fixed.
- Reset values: rom_A 0, rom_CS_b 1, rom_OE_b 1, cpu/vid_rdata 0, cpu/vid_rvalid 0, busy 0, tags NONE, streak 0, state IDLE. Acks are 0 while reset is high.
- Reset mid-operation: in-flight tags are flushed; no rvalid may appear for accesses issued before reset.
- First grant possible on the first edge with reset low (the ROM image is loaded during reset).
- Simultaneous requests: exactly one ack per cycle, never both.
- Request dropped before ack: no access; the requester is required not to do this (assertion in the bench).

## Configuration
- ROM_ARB_FAIR_EN defined: streak counter and CPU-forcing rule present; CPU waits at most MAX_STREAK+1 cycles under saturated video load.
- Undefined: strict video priority; streak logic removed; CPU may starve indefinitely.

## Structure
- Package rom_arb_pkg: owner_e enum (OWN_NONE, OWN_CPU, OWN_VID), grant state enum, ADDR_W/DATA_W defaults.
- Sub-module rom_arb_tag_pipe: 2-deep owner_e shift register with synchronous flush, exposing stage 1.
- Top module: grant logic, streak counter, ROM output registers, response registers.

## Test plan
- Single CPU read, ROM[0x0123]=0xA5: cpu_req at edge 0 → cpu_ack same cycle, cpu_rvalid pulse after edge 2 with cpu_rdata=0xA5; rom_CS_b back to 1.
- Video burst 0x0000–0x0007: one ack per cycle; vid_rvalid high 8 consecutive cycles; data in address order.
- Both request together, video addr 0x0010, CPU 0x2000: video acked first, CPU acked next cycle; responses return in that order to the correct ports.
- Fairness on (MAX_STREAK=4), video held continuously, CPU requests: 4 video grants, then CPU acked on the 5th cycle. Fairness off: CPU never acked while vid_req is high.
- Reset asserted one cycle after an accept: no rvalid afterward; all outputs at reset values; next read after reset returns correct data.
- Idle with rom_Dout driven Z: rdata holds previous value, rvalid stays 0, busy 0.
